// File: rtl/sample_frame_packer.sv
// sample_frame_packer: ping-pong capture of NUM_CH ADC samples, sent as a framed byte stream to a UART
// Optional trailing XOR checksum byte is enabled by defining SAMPLE_FRAME_PACKER_CSUM_EN.
module sample_frame_packer #(
  parameter int         NUM_CH = 32,
  parameter logic [7:0] HDR0   = 8'hA5,
  parameter logic [7:0] HDR1   = 8'h5A
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  input  logic [4:0]  smp_chan,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  seq_err_cnt
);
  localparam int            CW       = $clog2(NUM_CH);
  localparam int            IW       = CW + 1;
  localparam logic [4:0]    LAST_CH  = 5'(NUM_CH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_SEQ, S_DATA, S_CSUM} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    seq_err_cnt_q, seq_err_cnt_d;
  logic          cap_act_q, cap_act_d;
  logic [4:0]    exp_ch_q, exp_ch_d;
  logic          cap_sel_q, cap_sel_d;
  logic [15:0]   bank_q [2*NUM_CH];

  logic          in_seq, acc, err, done, go, drop, frame_end;
  logic [15:0]   send_word;
  logic [7:0]    data_byte;

  // capture qualification: in-order sample, or a channel-0 sample that (re)starts a frame
  always_comb begin
    in_seq    = cap_act_q && (smp_chan == exp_ch_q);
    acc       = smp_valid && (in_seq || smp_chan == 5'd0);
    err       = smp_valid && cap_act_q && !in_seq;
    done      = acc && (smp_chan == LAST_CH);
    go        = done && (state_q == S_IDLE);
    drop      = done && (state_q != S_IDLE);
    cap_act_d = acc ? !done : (err ? 1'b0 : cap_act_q);
    exp_ch_d  = acc ? smp_chan + 5'd1 : exp_ch_q;
    cap_sel_d = go ? ~cap_sel_q : cap_sel_q;
    drop_cnt_d    = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    seq_err_cnt_d = (err && seq_err_cnt_q != 8'hFF) ? seq_err_cnt_q + 8'd1 : seq_err_cnt_q;
  end

  // sample banks, not reset: contents are only read after a full frame has been written
  always_ff @(posedge clk25) begin
    if (acc) bank_q[{cap_sel_q, smp_chan[CW-1:0]}] <= smp_data;
  end

  // current data byte of the send bank, channel MSB first
  always_comb begin
    send_word = bank_q[{~cap_sel_q, idx_q[CW:1]}];
    data_byte = idx_q[0] ? send_word[7:0] : send_word[15:8];
  end

`ifdef SAMPLE_FRAME_PACKER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  assign frame_end = (state_q == S_CSUM) && tx_ready;

  // running XOR of seq and data bytes as they are transferred
  always_comb begin
    csum_d = csum_q;
    if (state_q == S_SEQ && tx_ready) csum_d = seq_q;
    if (state_q == S_DATA && tx_ready) csum_d = csum_q ^ data_byte;
  end

  // checksum register
  always_ff @(posedge clk25) begin
    if (!rst_n) csum_q <= 8'h00;
    else        csum_q <= csum_d;
  end
`else
  assign frame_end = (state_q == S_DATA) && tx_ready && (idx_q == LAST_IDX);
`endif

  // sender next state; a byte moves whenever tx_ready is high in a non-idle state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = frame_end ? seq_q + 8'd1 : seq_q;
    unique case (state_q)
      S_IDLE: state_d = go ? S_HDR0 : S_IDLE;
      S_HDR0: state_d = tx_ready ? S_HDR1 : S_HDR0;
      S_HDR1: state_d = tx_ready ? S_SEQ : S_HDR1;
      S_SEQ: begin
        state_d = tx_ready ? S_DATA : S_SEQ;
        idx_d   = '0;
      end
      S_DATA: begin
        idx_d = tx_ready ? idx_q + 1'b1 : idx_q;
`ifdef SAMPLE_FRAME_PACKER_CSUM_EN
        state_d = (tx_ready && idx_q == LAST_IDX) ? S_CSUM : S_DATA;
`else
        state_d = (tx_ready && idx_q == LAST_IDX) ? S_IDLE : S_DATA;
`endif
      end
      S_CSUM: state_d = tx_ready ? S_IDLE : S_CSUM;
      default: state_d = S_IDLE;
    endcase
  end

  // byte mux: held purely by state/index so it stays stable across stalls
  always_comb begin
    tx_valid = state_q != S_IDLE;
    busy     = state_q != S_IDLE;
    tx_data  = state_q == S_HDR0 ? HDR0 :
               state_q == S_HDR1 ? HDR1 :
               state_q == S_SEQ  ? seq_q :
               state_q == S_DATA ? data_byte :
`ifdef SAMPLE_FRAME_PACKER_CSUM_EN
               state_q == S_CSUM ? csum_q :
`endif
               8'h00;
  end

  // state and counter registers
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      seq_q         <= 8'h00;
      drop_cnt_q    <= 8'h00;
      seq_err_cnt_q <= 8'h00;
      cap_act_q     <= 1'b0;
      exp_ch_q      <= 5'd0;
      cap_sel_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      seq_q         <= seq_d;
      drop_cnt_q    <= drop_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
      cap_act_q     <= cap_act_d;
      exp_ch_q      <= exp_ch_d;
      cap_sel_q     <= cap_sel_d;
    end
  end

  assign drop_cnt    = drop_cnt_q;
  assign seq_err_cnt = seq_err_cnt_q;

endmodule
